// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg: shared definitions for the iterative multiplier.
// Holds the FSM state encoding, the default operand width and the
// iteration counter width derived from it.
package mul_iter_pkg;

    localparam int MUL_DATA_W = 32;
    localparam int MUL_CNT_W  = $clog2(MUL_DATA_W);

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage : mul_iter_pkg

// File: rtl/mul_iter_if.sv
// mul_iter_if: request/response bundle between the EX-stage ALU and the
// iterative multiplier.
//   master (ALU side)       : drives src_a, src_b, en, mul_sign, flush;
//                             receives hi, lo, res_ready, stall_all
//   slave  (multiplier side): the mirror image
interface mul_iter_if
    import mul_iter_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W
);
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              en;
    logic              mul_sign;
    logic              flush;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              res_ready;
    logic              stall_all;

    modport master (
        output src_a, src_b, en, mul_sign, flush,
        input  hi, lo, res_ready, stall_all
    );

    modport slave (
        input  src_a, src_b, en, mul_sign, flush,
        output hi, lo, res_ready, stall_all
    );
endinterface : mul_iter_if

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add DATA_W x DATA_W multiplier answering the
// ALU's multi-cycle request handshake (same contract as the divider).
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   bus   - mul_iter_if.slave: src_a/src_b/en/mul_sign/flush in,
//           hi/lo/res_ready/stall_all out
// A start in IDLE leads to res_ready DATA_W+1 cycles later. Signed
// operands are converted to magnitudes up front and the sign is
// re-applied to the finished 2*DATA_W product.
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    mul_iter_if.slave  bus
);

    localparam int CNT_W  = $clog2(DATA_W);
    localparam int PROD_W = 2 * DATA_W;

    mul_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    // Upper half accumulates partial products; the lower half starts out
    // holding the multiplier and fills with product bits as the multiplier
    // bits are consumed, so acc_reg[0] is always the current multiplier LSB.
    logic [PROD_W-1:0] acc_reg;
    logic [DATA_W-1:0] mcand_reg;
    logic              neg_reg;
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    logic              start;
    logic              last_step;
    logic              res_ready;
    logic [DATA_W:0]   sum;
    logic [PROD_W-1:0] acc_step;
    logic [PROD_W-1:0] prod;

    // Two's-complement magnitude; only negates signed negative values.
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(
        input logic [DATA_W-1:0] v,
        input logic              is_signed
    );
        if (is_signed && v[DATA_W-1])
            return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    assign start     = (state_reg == MUL_IDLE) && bus.en && !bus.flush;
    assign last_step = (cnt_reg == CNT_W'(DATA_W - 1));
    assign res_ready = (state_reg == MUL_DONE);

    // One shift-add step; the adder carry becomes the new MSB after the shift.
    always_comb begin
        sum      = {1'b0, acc_reg[PROD_W-1:DATA_W]}
                 + (acc_reg[0] ? {1'b0, mcand_reg} : {(DATA_W+1){1'b0}});
        acc_step = {sum, acc_reg[DATA_W-1:1]};
        prod     = neg_reg ? ({PROD_W{1'b0}} - acc_step) : acc_step;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MUL_IDLE: if (bus.en) state_next = MUL_BUSY;
            MUL_BUSY: begin
                if (!bus.en)        state_next = MUL_IDLE;  // request withdrawn
                else if (last_step) state_next = MUL_DONE;
            end
            MUL_DONE: state_next = MUL_IDLE;  // en still high here is not a new request
            default:  state_next = MUL_IDLE;
        endcase
        // Flush wins over everything, including a start on the same edge.
        if (bus.flush) state_next = MUL_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= MUL_IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mcand_reg <= '0;
            neg_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                mcand_reg <= magnitude(bus.src_a, bus.mul_sign);
                acc_reg   <= {{DATA_W{1'b0}}, magnitude(bus.src_b, bus.mul_sign)};
                neg_reg   <= bus.mul_sign & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                cnt_reg   <= '0;
            end else if (state_reg == MUL_BUSY) begin
                acc_reg <= acc_step;
                cnt_reg <= cnt_reg + CNT_W'(1);
                // Capture from the final step's result so DONE can present it.
                if (state_next == MUL_DONE)
                    {hi_reg, lo_reg} <= prod;
            end
        end
    end

    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;
    assign bus.res_ready = res_ready;
    assign bus.stall_all = bus.en & ~res_ready & ~bus.flush;

endmodule : mul_iter
